// File: rtl/cpu_divide_sequencer.sv
// Sequences one RISC-V M-extension divide/remainder through a fixed-latency external divider,
// short-circuiting divide-by-zero and signed overflow without waiting on the divider.
module cpu_divide_sequencer #(
    parameter int LATENCY = 2   // divider register stages, 1..14
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic        i_flush,
    output logic        o_signed,
    output logic [31:0] o_numerator,
    output logic [31:0] o_denominator,
    input  logic [31:0] i_div_result,
    input  logic [31:0] i_div_remainder,
    output logic        o_busy,
    output logic        o_ready,
    output logic [31:0] o_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY + 1);

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic [1:0]  op_reg, op_next;
    logic        signed_reg, signed_next;
    logic [31:0] num_reg, num_next;
    logic [31:0] den_reg, den_next;
    logic [31:0] rd_reg, rd_next;

    logic div_by_zero;
    logic signed_overflow;

    // op[0]=1 selects the unsigned variants, op[1]=1 selects remainder
    assign div_by_zero     = (i_rs2 == 32'd0);
    assign signed_overflow = !i_op[0] && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            op_reg     <= '0;
            signed_reg <= 1'b0;
            num_reg    <= '0;
            den_reg    <= '0;
            rd_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            op_reg     <= op_next;
            signed_reg <= signed_next;
            num_reg    <= num_next;
            den_reg    <= den_next;
            rd_reg     <= rd_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        op_next     = op_reg;
        signed_next = signed_reg;
        num_next    = num_reg;
        den_next    = den_reg;
        rd_next     = rd_reg;
        case (state_reg)
            IDLE: begin
                if (i_request && !i_flush) begin
                    num_next    = i_rs1;
                    den_next    = i_rs2;
                    signed_next = !i_op[0];
                    op_next     = i_op;
                    if (div_by_zero) begin
                        rd_next    = i_op[1] ? i_rs1 : 32'hFFFF_FFFF;
                        state_next = DONE;
                    end else if (signed_overflow) begin
                        rd_next    = i_op[1] ? 32'd0 : 32'h8000_0000;
                        state_next = DONE;
                    end else begin
                        count_next = COUNT_LOAD;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (i_flush) begin
                    count_next = '0;
                    state_next = IDLE;
                end else if (count_reg == 4'd1) begin
                    rd_next    = op_reg[1] ? i_div_remainder : i_div_result;
                    count_next = '0;
                    state_next = DONE;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                count_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign o_busy        = (state_reg != IDLE);
    assign o_ready       = (state_reg == DONE);
    assign o_signed      = signed_reg;
    assign o_numerator   = num_reg;
    assign o_denominator = den_reg;
    assign o_rd          = rd_reg;

endmodule

// File: tb/tb_cpu_divide_sequencer.sv
// Bench for cpu_divide_sequencer: pipelined divider model, expected-result scoreboard
// checked on every o_ready strobe, plus directed flush/reset/ignore scenarios.
module tb_cpu_divide_sequencer;

    localparam int LATENCY = 2;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_request = 1'b0;
    logic [1:0]  i_op = 2'd0;
    logic [31:0] i_rs1 = '0;
    logic [31:0] i_rs2 = '0;
    logic        i_flush = 1'b0;
    logic        o_signed;
    logic [31:0] o_numerator;
    logic [31:0] o_denominator;
    logic [31:0] i_div_result;
    logic [31:0] i_div_remainder;
    logic        o_busy;
    logic        o_ready;
    logic [31:0] o_rd;

    cpu_divide_sequencer #(.LATENCY(LATENCY)) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_request       (i_request),
        .i_op            (i_op),
        .i_rs1           (i_rs1),
        .i_rs2           (i_rs2),
        .i_flush         (i_flush),
        .o_signed        (o_signed),
        .o_numerator     (o_numerator),
        .o_denominator   (o_denominator),
        .i_div_result    (i_div_result),
        .i_div_remainder (i_div_remainder),
        .o_busy          (o_busy),
        .o_ready         (o_ready),
        .o_rd            (o_rd)
    );

    always #5 i_clock = ~i_clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge i_clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // divider model: LATENCY register stages; garbage on cases the sequencer must bypass
    function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] n, input logic [31:0] d);
        logic [31:0] q, r;
        if (d == 32'd0) begin
            q = 32'hDEAD_BEEF; r = 32'hDEAD_BEEF;
        end else if (sgn && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
            q = 32'hBAD0_BAD0; r = 32'hBAD0_BAD0;
        end else if (sgn) begin
            q = 32'($signed(n) / $signed(d));
            r = 32'($signed(n) % $signed(d));
        end else begin
            q = n / d;
            r = n % d;
        end
        return {q, r};
    endfunction

    logic [31:0] q_pipe [LATENCY];
    logic [31:0] r_pipe [LATENCY];
    logic [63:0] model_out;

    assign model_out = div_model(o_signed, o_numerator, o_denominator);

    always @(posedge i_clock) begin
        q_pipe[0] <= model_out[63:32];
        r_pipe[0] <= model_out[31:0];
        for (int i = 1; i < LATENCY; i++) begin
            q_pipe[i] <= q_pipe[i-1];
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign i_div_result    = q_pipe[LATENCY-1];
    assign i_div_remainder = r_pipe[LATENCY-1];

    function automatic logic [31:0] ref_rd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] qr;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        qr = div_model(!op[0], a, b);
        return op[1] ? qr[31:0] : qr[63:32];
    endfunction

    typedef struct {
        logic [31:0] rd;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    logic prev_ready = 1'b0;

    always @(negedge i_clock) begin
        exp_t e;
        if (i_reset) begin
            if (prev_ready) check("ready_width", 32'(o_ready), 32'd0);
            if (o_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_ready", 32'(o_ready), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("o_rd", o_rd, e.rd);
                    check("ready_cycle", 32'(cyc), 32'(e.due));
                    $display("completion rd=0x%08h expected=0x%08h cycle=%0d", o_rd, e.rd, cyc);
                end
            end
        end
        prev_ready = o_ready;
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_rd);
        exp_t e;
        logic byp;
        byp = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        @(negedge i_clock);
        i_request = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b;
        @(posedge i_clock); #1;
        i_request = 1'b0;
        e.rd  = exp_rd;
        e.due = byp ? cyc : cyc + LATENCY + 1;
        sb_q.push_back(e);
        $display("issue op=%0d rs1=0x%08h rs2=0x%08h expect=0x%08h bypass=%0d", op, a, b, exp_rd, byp);
        check("numerator", o_numerator, a);
        check("denominator", o_denominator, b);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || o_busy) && n < 40) begin
            @(posedge i_clock); #2;
            n++;
        end
        if (n >= 40) check("wait_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        // reset state, asynchronous with no clock edge involved
        #2;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_rd", o_rd, 32'd0);
        check("rst_num", o_numerator, 32'd0);
        check("rst_den", o_denominator, 32'd0);
        check("rst_signed", 32'(o_signed), 32'd0);
        repeat (2) @(posedge i_clock);
        #1 i_reset = 1'b1;

        // first request lands on the first edge after reset release
        issue(2'd1, 32'd100, 32'd7, 32'd14);
        wait_done();
        issue(2'd3, 32'd100, 32'd7, 32'd2);
        wait_done();

        issue(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        check("signed_wait", 32'(o_signed), 32'd1);
        @(posedge i_clock); #1;
        check("signed_wait2", 32'(o_signed), 32'd1);
        wait_done();
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        wait_done();

        issue(2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF);
        wait_done();
        issue(2'd2, 32'h1234_5678, 32'd0, 32'h1234_5678);
        wait_done();

        issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_done();
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        wait_done();
        issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        wait_done();

        // request while WAIT must be ignored
        issue(2'd1, 32'd100, 32'd7, 32'd14);
        @(negedge i_clock);
        i_request = 1'b1; i_op = 2'd1; i_rs1 = 32'd9; i_rs2 = 32'd3;
        @(posedge i_clock); #1;
        i_request = 1'b0;
        check("ignored_num", o_numerator, 32'd100);
        wait_done();
        check("after_ignore_rd", o_rd, 32'd14);

        // flush one edge into WAIT
        issue(2'd1, 32'd20, 32'd4, 32'd5);
        void'(sb_q.pop_back());
        @(negedge i_clock);
        i_flush = 1'b1;
        @(posedge i_clock); #1;
        i_flush = 1'b0;
        check("flush_busy", 32'(o_busy), 32'd0);
        repeat (6) @(posedge i_clock);
        #1 check("flush_rd", o_rd, 32'd14);

        // flush and request together in IDLE: no acceptance
        @(negedge i_clock);
        i_flush = 1'b1; i_request = 1'b1; i_op = 2'd1; i_rs1 = 32'd50; i_rs2 = 32'd0;
        @(posedge i_clock); #1;
        i_flush = 1'b0; i_request = 1'b0;
        check("flush_req_busy", 32'(o_busy), 32'd0);
        check("flush_req_num", o_numerator, 32'd20);

        // reset mid-WAIT
        issue(2'd1, 32'd77, 32'd5, 32'd15);
        void'(sb_q.pop_back());
        @(negedge i_clock);
        i_reset = 1'b0;
        #1;
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_rd", o_rd, 32'd0);
        check("midrst_num", o_numerator, 32'd0);
        check("midrst_den", o_denominator, 32'd0);
        check("midrst_signed", 32'(o_signed), 32'd0);
        repeat (2) @(posedge i_clock);
        #1 i_reset = 1'b1;
        repeat (6) @(posedge i_clock);
        #1 check("postrst_busy", 32'(o_busy), 32'd0);
        issue(2'd1, 32'd9, 32'd3, 32'd3);
        wait_done();

        // random mix against the reference semantics
        for (int k = 0; k < 10; k++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (k == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            issue(op, a, b, ref_rd(op, a, b));
            wait_done();
        end

        repeat (3) @(posedge i_clock);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_divide_sequencer.md
CPU_DIVIDE_SEQUENCER -- requirements
Module: CPU_Divide_Sequencer

Interface
REQ-001 Parameter LATENCY, default 2, legal range 1..14: register stages of the downstream divider between its operand inputs and its o_result/o_remainder.
REQ-002 Port i_clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 Port i_reset  in  1  asynchronous, active-low reset.
REQ-004 Port i_request  in  1  single-cycle strobe, start one divide/remainder operation.
REQ-005 Port i_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU (RISC-V M semantics).
REQ-006 Port i_rs1, i_rs2  in  32 each  dividend, divisor.
REQ-007 Port i_flush  in  1  abort in-flight operation.
REQ-008 Port o_signed  out  1  signed-mode select driven to the divider.
REQ-009 Port o_numerator, o_denominator  out  32 each  registered operands driven to the divider.
REQ-010 Port i_div_result, i_div_remainder  in  32 each  divider quotient/remainder, valid LATENCY edges after operands change.
REQ-011 Port o_busy  out  1  high whenever state is not IDLE.
REQ-012 Port o_ready  out  1  one-cycle completion strobe.
REQ-013 Port o_rd  out  32  final architectural result; held until next completion.

Function
REQ-014 States IDLE, WAIT, DONE; a registered 4-bit down-counter shall time WAIT.
REQ-015 A request shall be accepted only when i_request=1 at a rising edge with state IDLE and i_flush=0; requests in WAIT or DONE shall be ignored with no state effect.
REQ-016 On acceptance, o_numerator<=i_rs1, o_denominator<=i_rs2, o_signed<=(i_op==DIV or REM), op latched internally; operand outputs shall stay stable until the next acceptance.
REQ-017 Divide-by-zero (i_rs2==0) on acceptance: bypass the divider, go IDLE->DONE directly; o_rd<=0xFFFFFFFF for DIV/DIVU, o_rd<=i_rs1 for REM/REMU.
REQ-018 Signed overflow (DIV/REM, i_rs1==0x80000000, i_rs2==0xFFFFFFFF) on acceptance: bypass, IDLE->DONE; o_rd<=0x80000000 for DIV, 0 for REM.
REQ-019 Otherwise IDLE->WAIT with counter loaded LATENCY+1; counter decrements each edge in WAIT.
REQ-020 At the WAIT edge where counter==1: o_rd<=i_div_result (DIV/DIVU) or i_div_remainder (REM/REMU); state->DONE.
REQ-021 o_ready shall be 1 exactly during DONE; DONE->IDLE unconditionally on the next edge.
REQ-022 Latency: acceptance edge E0; o_ready high in cycle after E0+LATENCY+1 (normal) or after E0 (bypass).
REQ-023 i_flush=1 at an edge in WAIT or DONE shall force IDLE, leave o_rd unchanged, and suppress/terminate o_ready; i_flush in IDLE blocks acceptance that cycle.
REQ-024 i_flush and i_request high together in IDLE: flush wins, no acceptance.
REQ-025 o_rd shall change only at completion edges (REQ-017/018/020) and reset.
REQ-026 o_busy shall be combinational from state only; no output shall depend combinationally on i_request.

Reset
REQ-027 i_reset low shall immediately force state IDLE, counter 0, o_busy 0, o_ready 0, o_rd 0, o_numerator 0, o_denominator 0, o_signed 0, regardless of clock.
REQ-028 Reset asserted mid-WAIT or in DONE shall discard the operation; no o_ready after release.
REQ-029 First acceptance possible at the first rising edge after i_reset rises.

Verification
REQ-030 LATENCY=2, DIVU 100/7 at E0 with divider model -> o_ready in cycle after E3, o_rd=14; REMU same operands -> o_rd=2.
REQ-031 DIV 0xFFFFFFF9(-7)/2 -> o_rd=0xFFFFFFFD; REM same -> o_rd=0xFFFFFFFF; o_signed=1 throughout WAIT.
REQ-032 DIVU 5/0 -> o_ready cycle after E0, o_rd=0xFFFFFFFF; REM 0x12345678/0 -> o_rd=0x12345678; divider outputs ignored.
REQ-033 DIV 0x80000000/0xFFFFFFFF -> o_rd=0x80000000 after one cycle; REM same -> 0; DIVU same -> normal WAIT path, o_rd=0.
REQ-034 Accept DIVU 100/7, strobe i_request with 9/3 at E1 -> ignored, o_rd=14; then i_flush at E1 of new op -> o_busy 0 next cycle, no o_ready, o_rd remains 14.
REQ-035 Assert i_reset low mid-WAIT -> all outputs zero asynchronously, no o_ready after release; DIVU 9/3 after release -> o_rd=3.
